// File: rtl/pads_sound_v2.sv
// pads_sound_v2: AXI4-Lite register slave driving NUM_CH square-wave tone
// channels. Each channel toggles its tone bit every PERIOD[ch] clock cycles
// while enabled; SOUND_MIX reports how many tones are currently high.
//
// Handshake semantics: a transfer on any channel completes on the rising edge
// where VALID and READY are both high. AWREADY/WREADY are raised together only
// while AWVALID, WVALID and no pending BVALID are all present, so one write is
// outstanding at most. ARREADY is raised only while ARVALID and no pending
// RVALID are present. BVALID/RVALID rise the cycle after acceptance and hold
// (with RDATA frozen) until BREADY/RREADY is sampled high.
module pads_sound_v2 #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CH             = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_CH-1:0]                 TONE_OUT,
  output logic [$clog2(NUM_CH+1)-1:0]       SOUND_MIX
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int MW = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0] r_ctrl;
  logic [DW-1:0]     r_period [NUM_CH];
  logic [DW-1:0]     r_cnt    [NUM_CH];
  logic [NUM_CH-1:0] r_t;
  logic [MW-1:0]     r_mix;
  logic              r_bvalid;
  logic              r_rvalid;
  logic [DW-1:0]     r_rdata;

  logic              w_wr_en;
  logic              w_rd_en;
  logic [IW-1:0]     w_wr_idx;
  logic [IW-1:0]     w_rd_idx;
  logic [DW-1:0]     w_ctrl_full;
  logic [DW-1:0]     w_rd_data;
  logic              w_unused;

  // Replace the bytes of old selected by strb with the matching bytes of wd.
  function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] wd,
                                            input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [MW-1:0] f_popcount(input logic [NUM_CH-1:0] v);
    logic [MW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_CH; i++) c = c + MW'(v[i]);
    return c;
  endfunction

  // Readies are combinational so the first edge after reset can already accept;
  // gating with ARESETN keeps them low while reset is held.
  assign w_wr_en       = S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ARESETN;
  assign w_rd_en       = S_AXI_ARVALID & ~r_rvalid & ARESETN;
  assign S_AXI_AWREADY = w_wr_en;
  assign S_AXI_WREADY  = w_wr_en;
  assign S_AXI_ARREADY = w_rd_en;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign TONE_OUT      = r_t;
  assign SOUND_MIX     = r_mix;

  assign w_wr_idx    = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_rd_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_ctrl_full = f_merge(DW'(r_ctrl), S_AXI_WDATA, S_AXI_WSTRB);
  assign w_unused    = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[1:0], w_ctrl_full[DW-1:NUM_CH]};

  // Read mux: CTRL, live tone bits as STATUS, then the PERIOD bank; rest is 0.
  always_comb begin
    w_rd_data = '0;
    if (w_rd_idx == IW'(0)) begin
      w_rd_data[NUM_CH-1:0] = r_ctrl;
    end else if (w_rd_idx == IW'(1)) begin
      w_rd_data[NUM_CH-1:0] = r_t;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (w_rd_idx == IW'(ch + 2)) w_rd_data = r_period[ch];
      end
    end
  end

  // Register bank update on the write acceptance edge, byte-merged by WSTRB.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_ctrl <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) r_period[ch] <= '0;
    end else if (w_wr_en) begin
      if (w_wr_idx == IW'(0)) r_ctrl <= w_ctrl_full[NUM_CH-1:0];
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (w_wr_idx == IW'(ch + 2))
          r_period[ch] <= f_merge(r_period[ch], S_AXI_WDATA, S_AXI_WSTRB);
      end
    end
  end

  // Write response: raised after acceptance, held until BREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_bvalid <= 1'b0;
    else if (w_wr_en) r_bvalid <= 1'b1;
    else if (r_bvalid && S_AXI_BREADY) r_bvalid <= 1'b0;
  end

  // Read response: data captured from pre-write register state on acceptance.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_rd_en) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  // Tone generators: count to PERIOD-1 then toggle; a new PERIOD applies at
  // once without clearing the count, so an overshot count toggles immediately.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_t <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) r_cnt[ch] <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (!r_ctrl[ch] || (r_period[ch] == '0)) begin
          r_cnt[ch] <= '0;
          r_t[ch]   <= 1'b0;
        end else if (r_cnt[ch] >= (r_period[ch] - DW'(1))) begin
          r_cnt[ch] <= '0;
          r_t[ch]   <= ~r_t[ch];
        end else begin
          r_cnt[ch] <= r_cnt[ch] + DW'(1);
        end
      end
    end
  end

  // Mixer: population count of the tone bits, one cycle behind TONE_OUT.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_mix <= '0;
    else r_mix <= f_popcount(r_t);
  end

endmodule

// File: tb/tb_pads_sound_v2.sv
// Testbench for pads_sound_v2: register vectors from a table, hand-built
// handshake corner cases, and random traffic checked against a register model
// and a closed-form tone model (tone after k edges of period P = (k/P) mod 2).
module tb_pads_sound_v2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [3:0]  tone_out;
  logic [2:0]  sound_mix;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [5:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  pads_sound_v2 dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready), .TONE_OUT(tone_out), .SOUND_MIX(sound_mix)
  );

  // Clock and edge counter (cyc == n between edge n and edge n+1).
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    $display("FAIL %s: got no handshake within budget, expected one", nm);
  endtask

  // Tone of a channel enabled on edge a with half-period p, after edge n.
  function automatic int tone_model(input int n, input int a, input int p);
    if (n <= a) return 0;
    return ((n - a) / p) % 2;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int acc);
    bit done;
    acc = -1;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (awready && wready) begin
        acc = cyc + 1;
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!done) begin
      timeout_fail("wr_accept");
      return;
    end
    bready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bvalid) begin
        chk("bresp", 32'(bresp), 32'h0);
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    bready = 1'b0;
    if (!done) timeout_fail("wr_bvalid");
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d,
                          output logic [1:0] r, output int acc);
    bit done;
    acc = -1; d = 'x; r = 'x;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (arready) begin
        acc = cyc + 1;
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    arvalid = 1'b0;
    if (!done) begin
      timeout_fail("rd_accept");
      return;
    end
    rready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (rvalid) begin
        d = rdata; r = rresp;
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    rready = 1'b0;
    if (!done) timeout_fail("rd_rvalid");
  endtask

  initial begin
    logic [31:0] d, m;
    logic [1:0]  r;
    logic [5:0]  wa, ra;
    logic [3:0]  s;
    logic [31:0] model [16];
    int ac, ar, w, p, wi, rw;
    bit done;

    vecs[0] = '{6'h08, 32'h12345678, 4'hF, 6'h08, 32'h12345678};
    vecs[1] = '{6'h0B, 32'h0000000A, 4'hF, 6'h08, 32'h0000000A};
    vecs[2] = '{6'h00, 32'hFFFFFFFF, 4'hF, 6'h00, 32'h0000000F};
    vecs[3] = '{6'h00, 32'h00000000, 4'hF, 6'h00, 32'h00000000};
    vecs[4] = '{6'h04, 32'hFFFFFFFF, 4'hF, 6'h04, 32'h00000000};
    vecs[5] = '{6'h18, 32'hDEADBEEF, 4'hF, 6'h18, 32'h00000000};
    vecs[6] = '{6'h3C, 32'hFFFFFFFF, 4'hF, 6'h3C, 32'h00000000};
    vecs[7] = '{6'h14, 32'hAABBCCDD, 4'hA, 6'h14, 32'hAA00CC00};
    vecs[8] = '{6'h14, 32'h11223344, 4'h1, 6'h14, 32'hAA00CC44};
    vecs[9] = '{6'h10, 32'hFFFFFFFF, 4'h0, 6'h10, 32'h00000000};

    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    do_reset();

    // Reset state and reset read-back of every mapped register.
    chk("rst_tone", 32'(tone_out), 32'h0);
    chk("rst_mix", 32'(sound_mix), 32'h0);
    chk("rst_bvalid", 32'(bvalid), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    for (int i = 0; i < 6; i++) begin
      axi_read(6'(4 * i), d, r, ar);
      chk("rst_read", d, 32'h0);
      chk("rst_rresp", 32'(r), 32'h0);
    end

    // Table-driven register write/readback vectors.
    foreach (vecs[i]) begin
      axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, ac);
      axi_read(vecs[i].raddr, d, r, ar);
      chk($sformatf("vec%0d", i), d, vecs[i].exp);
    end

    // Byte-strobed write after clearing PERIOD[1].
    axi_write(6'h0C, 32'h0, 4'hF, ac);
    axi_write(6'h0C, 32'hAABBCCDD, 4'b0101, ac);
    axi_read(6'h0C, d, r, ar);
    chk("strb_period1", d, 32'h00BB00DD);

    // Simultaneous read and write of one register returns the old value.
    axi_write(6'h08, 32'h11, 4'hF, ac);
    @(posedge clk); #1;
    awaddr = 6'h08; wdata = 32'h22; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h08; arvalid = 1'b1;
    @(negedge clk);
    chk("rw_awready", 32'(awready), 32'h1);
    chk("rw_arready", 32'(arready), 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    chk("rw_rvalid", 32'(rvalid), 32'h1);
    chk("rw_rdata_old", rdata, 32'h11);
    chk("rw_bvalid", 32'(bvalid), 32'h1);
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    axi_read(6'h08, d, r, ar);
    chk("rw_new_value", d, 32'h22);

    // Back-pressured write response blocks a second write.
    @(posedge clk); #1;
    awaddr = 6'h08; wdata = 32'h7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    chk("bp_first_ready", 32'(awready), 32'h1);
    @(posedge clk); #1;
    awaddr = 6'h0C; wdata = 32'h9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_bvalid_held", 32'(bvalid), 32'h1);
      chk("bp_awready_low", 32'(awready), 32'h0);
      chk("bp_wready_low", 32'(wready), 32'h0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("bp_bvalid_done", 32'(bvalid), 32'h0);
    chk("bp_second_ready", 32'(awready), 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (bvalid) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    bready = 1'b0;
    if (!done) timeout_fail("bp_second_b");
    axi_read(6'h08, d, r, ar);
    chk("bp_first_data", d, 32'h7);
    axi_read(6'h0C, d, r, ar);
    chk("bp_second_data", d, 32'h9);

    // Random register traffic against a register model.
    do_reset();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    for (int i = 0; i < 40; i++) begin
      wa = 6'($urandom_range(0, 63));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      axi_write(wa, d, s, ac);
      wi = int'(wa) / 4;
      m = model[wi];
      for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
      if (wi == 0) model[0] = m & 32'hF;
      else if (wi >= 2 && wi <= 5) model[wi] = m;
      rw = $urandom_range(0, 14);
      if (rw >= 1) rw++;
      ra = 6'(rw * 4 + $urandom_range(0, 3));
      axi_read(ra, d, r, ar);
      chk("rand_reg", d, model[rw]);
    end

    // Channel 0 at half-period 3: tone, mix and STATUS.
    do_reset();
    axi_write(6'h08, 32'd3, 4'hF, ac);
    axi_write(6'h00, 32'h1, 4'hF, ac);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      chk("tone_ch0", 32'(tone_out), 32'(tone_model(cyc, ac, 3)));
      chk("mix_ch0", 32'(sound_mix), 32'(tone_model(cyc - 1, ac, 3)));
    end
    axi_read(6'h04, d, r, ar);
    chk("status_ch0", d, 32'(tone_model(ar - 1, ac, 3)));

    // Random half-periods on channel 1.
    for (int it = 0; it < 3; it++) begin
      p = $urandom_range(1, 7);
      do_reset();
      axi_write(6'h0C, 32'(p), 4'hF, ac);
      axi_write(6'h00, 32'h2, 4'hF, ac);
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        chk("tone_rnd_ch1", 32'(tone_out), 32'(tone_model(cyc, ac, p) << 1));
      end
    end

    // Retune channel 2 from 100 to 10 mid-count: toggle on the next edge.
    do_reset();
    axi_write(6'h10, 32'd100, 4'hF, ac);
    axi_write(6'h00, 32'h4, 4'hF, ac);
    for (int i = 0; i < 200 && cyc < ac + 48; i++) @(negedge clk);
    chk("retune_pre", 32'(tone_out), 32'h0);
    axi_write(6'h10, 32'd10, 4'hF, w);
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      p = (cyc <= w) ? 0 : 1 - (((cyc - w - 1) / 10) % 2);
      chk("retune_ch2", 32'(tone_out), 32'(p << 2));
    end

    // Four channels at half-period 1, then reset in the middle of a write.
    do_reset();
    for (int ch = 0; ch < 4; ch++) axi_write(6'(8 + 4 * ch), 32'd1, 4'hF, ac);
    axi_write(6'h00, 32'hF, 4'hF, ac);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("all_tone", 32'(tone_out), (tone_model(cyc, ac, 1) != 0) ? 32'hF : 32'h0);
      chk("all_mix", 32'(sound_mix), (tone_model(cyc - 1, ac, 1) != 0) ? 32'd4 : 32'd0);
    end
    @(posedge clk); #1;
    awaddr = 6'h08; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("midrst_ready_before", 32'(awready), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_awready", 32'(awready), 32'h0);
    chk("midrst_wready", 32'(wready), 32'h0);
    chk("midrst_arready", 32'(arready), 32'h0);
    chk("midrst_bvalid", 32'(bvalid), 32'h0);
    chk("midrst_rvalid", 32'(rvalid), 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_resp", 32'({bresp, rresp}), 32'h0);
    chk("midrst_tone", 32'(tone_out), 32'h0);
    chk("midrst_mix", 32'(sound_mix), 32'h0);
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("midrst_no_bvalid", 32'(bvalid), 32'h0);
    end
    axi_read(6'h08, d, r, ar);
    chk("midrst_period0", d, 32'h0);
    axi_read(6'h00, d, r, ar);
    chk("midrst_ctrl", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pads_sound_v2.md
PADS_SOUND_V2 -- requirements
Module: pads_sound_v2

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, SHALL set AXI data and period-register width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 6, SHALL set AXI address width; it must be large enough to cover 0x08+4*(NUM_CH-1).
REQ-003 Parameter NUM_CH, default 4, legal 1..8, SHALL set the number of tone channels.
REQ-004 Port list, one port per line: name, direction, width, meaning.
- ACLK  in  1  single clock; all logic is on the rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
- S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte-write enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
- S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.
- TONE_OUT  out  NUM_CH  per-channel square wave.
- SOUND_MIX  out  clog2(NUM_CH+1)  count of TONE_OUT bits that are high.

Function
REQ-005 The register map SHALL use word addresses, with address bits [1:0] ignored.
- 0x00 CTRL: RW; bits [NUM_CH-1:0] are channel enables; upper bits read 0.
- 0x04 STATUS: RO; bits [NUM_CH-1:0] equal TONE_OUT.
- 0x08+4*ch PERIOD[ch]: RW; half-period in ACLK cycles.
REQ-006 Unmapped addresses SHALL read 0 and ignore writes; all responses (BRESP, RRESP) SHALL be OKAY (2'b00).
REQ-007 Write acceptance: AWREADY and WREADY SHALL pulse high together for exactly one cycle, only when AWVALID, WVALID and !BVALID are all true.
- AW-only or W-only requests SHALL wait; nothing is accepted.
REQ-008 The register update SHALL occur on the acceptance edge, applied per byte according to WSTRB.
- Writes to STATUS are ignored.
REQ-009 BVALID SHALL rise the cycle after acceptance and hold until BREADY is sampled high; at most one write is outstanding.
REQ-010 Read acceptance: ARREADY SHALL pulse high for one cycle when ARVALID and !RVALID are true.
REQ-011 RDATA SHALL be registered on the acceptance edge.
- RVALID rises the next cycle and holds until RREADY.
- RDATA is stable while RVALID is high.
REQ-012 A simultaneous read and write to the same register SHALL return the pre-write value.
REQ-013 Each channel SHALL keep a C_S_AXI_DATA_WIDTH counter CNT[ch] and a tone bit T[ch].
REQ-014 If CTRL[ch]=0 or PERIOD[ch]=0, then CNT[ch]<=0 and T[ch]<=0 on every edge.
REQ-015 Otherwise, per edge:
- if CNT[ch] >= PERIOD[ch]-1, then CNT[ch]<=0 and T[ch] toggles;
- else CNT[ch]<=CNT[ch]+1.
- This gives a square wave of period 2*PERIOD cycles; PERIOD=1 toggles every cycle.
REQ-016 A PERIOD write while a channel runs SHALL take effect on the next edge with no counter reset.
- If CNT already >= the new PERIOD-1, the toggle occurs on that next edge.
REQ-017 TONE_OUT SHALL equal T registered, with no combinational path from the AXI inputs.
REQ-018 SOUND_MIX SHALL be the registered population count of T, lagging TONE_OUT by one cycle.

Reset
REQ-019 While ARESETN=0, asynchronously and regardless of any in-flight handshake:
- all AXI ready/valid outputs, BRESP, RRESP and RDATA are 0;
- CTRL, all PERIOD registers, CNT, T, TONE_OUT and SOUND_MIX are 0.
REQ-020 An in-flight transaction SHALL be discarded by reset.
- The first acceptance is possible on the first edge after ARESETN rises.

Verification
REQ-021 Reset then read 0x00, 0x04, 0x08..0x14 -> every read returns 0x00000000 with RRESP=OKAY.
REQ-022 Write PERIOD[0]=3, then CTRL=0x1 -> TONE_OUT[0] toggles every 3 cycles (period 6); SOUND_MIX follows one cycle later; STATUS[0] matches TONE_OUT[0].
REQ-023 Write 0xAABBCCDD to 0x0C with WSTRB=4'b0101, after PERIOD[1]=0 -> PERIOD[1] reads 0x00BB00DD.
REQ-024 Hold BREADY=0 for 5 cycles after a write -> BVALID is held, AWREADY/WREADY stay 0 for a second pending write, and the second write is accepted after the B handshake.
REQ-025 PERIOD[2]=100 running, CNT at 50, write PERIOD[2]=10 -> T[2] toggles on the next edge, then every 10 cycles.
REQ-026 Channels 0..3 enabled with PERIOD=1 -> SOUND_MIX alternates 4/0; assert ARESETN=0 mid-write -> all outputs are 0 immediately and BVALID never rises for that write.
